fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage's control unit. Holds the PC, reads 16-bit words from instruction memory, assembles two-word instructions (opcode word plus 16-bit immediate), and drives the IF/ID pipeline register. It honours stall and redirect requests from the hazard and branch logic.

## Interface
- `PC_W`, 32: PC and instruction-memory address width (word addressed).
- `INSTR_W`, 16: instruction word width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_addr`  out  PC_W: word address to instruction memory.
- `imem_rdata`  in  INSTR_W: word at `imem_addr`; combinational (same-cycle) read.
- `stall`  in  1: hold PC, FSM state and IF/ID contents.
- `redirect`  in  1: taken branch, CALL, RET or RTI; load `redirect_pc`.
- `redirect_pc`  in  PC_W: new fetch address.
- `ifid_valid`  out  1: IF/ID holds a real instruction; 0 is a bubble (NOP).
- `ifid_instr`  out  INSTR_W: instruction word; opcode in [15:11].
- `ifid_imm`  out  INSTR_W: immediate word for two-word instructions, else 0.
- `ifid_pc`  out  PC_W: address of the instruction's first word.
- `pc`  out  PC_W: current fetch PC (debug/observability).

## Operation
- FSM states: BOOT, FETCH_OP, FETCH_IMM.
- Reset values: state=BOOT, pc=0, ifid_valid=0, ifid_instr=0, ifid_imm=0, ifid_pc=0.
- `imem_addr` = 0 in BOOT, otherwise `pc`.
- BOOT (one cycle, unconditional): pc <= zero-extended `imem_rdata` (reset vector M[0]). IF/ID stays invalid. Next state FETCH_OP. `stall` and `redirect` are ignored in BOOT.
- Two-word opcodes: LDM 11010, LDD 00111, STD 01100. All others are single-word.
- FETCH_OP with a single-word opcode: IF/ID <= {valid=1, instr=rdata, imm=0, pc=pc}; pc <= pc+1.
- FETCH_OP with a two-word opcode: latch rdata and pc into internal hold registers; IF/ID valid <= 0; pc <= pc+1; next state FETCH_IMM.
- FETCH_IMM: IF/ID <= {valid=1, instr=held word, imm=rdata, pc=held pc}; pc <= pc+1; next state FETCH_OP.
- Priority in FETCH_OP and FETCH_IMM: rst > redirect > stall > normal.
- redirect: pc <= redirect_pc; IF/ID valid <= 0 and instr/imm <= 0; any held half-instruction is discarded; state <= FETCH_OP.
- stall (no redirect): pc, state, hold registers and all IF/ID outputs keep their values.
- PC arithmetic is modulo 2^PC_W; 0xFFFF_FFFF+1 wraps to 0. A two-word instruction whose immediate wraps to address 0 is legal.
- Undefined opcodes are forwarded as single-word, and decode handles them.

## Timing
- The word at `pc` is in IF/ID after 1 edge for single-word instructions and after 2 edges for two-word instructions, with one bubble in between.
- The first valid IF/ID entry appears 2 edges after reset deasserts (BOOT edge, then fetch edge).
- Redirect takes effect at the asserting edge. The target word is in IF/ID on the following edge.
- Asserting reset mid-operation immediately clears all state and outputs asynchronously. Fetch restarts with BOOT.
- Steady-state throughput is 1 instruction per cycle for single-word instructions and 1 per 2 cycles for two-word instructions.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OPC_LDM, OPC_LDD, OPC_STD, …), also used by decode;
  - `is_two_word(opcode)` function;
  - `fetch_state_t` enum.
- Sub-module `ifid_reg`: IF/ID register with async reset, enable (not stall) and clear (redirect). The FSM and PC logic stay in `fetch_stage`.

## Test plan
- Reset, M[0]=0x0020, M[0x20]=0x9800 (ADD) → BOOT edge gives pc=0x20 and valid=0; next edge gives ifid_instr=0x9800, ifid_pc=0x20, pc=0x21.
- M[0x21]=0xD000 (LDM), M[0x22]=0x1234 → one bubble, then ifid_instr=0xD000, ifid_imm=0x1234, ifid_pc=0x21, pc=0x23.
- Stall held 3 cycles during streaming → pc and all IF/ID outputs unchanged. Release resumes at the same pc with no skipped word.
- redirect=1, redirect_pc=0x40 while in FETCH_IMM of an STD → held word dropped, valid=0; next edge ifid_pc=0x40 and the STD never appears.
- stall=1 and redirect=1 on the same edge → redirect wins; pc=redirect_pc, valid=0.
- pc=0xFFFF_FFFF with a single-word instruction → pc wraps to 0. Reset asserted mid-FETCH_IMM → outputs zero immediately and BOOT re-reads M[0].

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM states
// and the two-word instruction classifier used by fetch and decode.
package cpu_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_LDM = 5'b11010;
    localparam logic [OPC_W-1:0] OPC_LDD = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_STD = 5'b01100;

    typedef enum logic [1:0] {
        BOOT,
        FETCH_OP,
        FETCH_IMM
    } fetch_state_t;

    // Opcodes followed by a 16-bit immediate word
    function automatic logic is_two_word(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LDM) || (opc == OPC_LDD) || (opc == OPC_STD);
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear drops the entry to a bubble,
// enable loads a new entry, otherwise contents are held.
module ifid_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               d_valid,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [INSTR_W-1:0] d_imm,
    input  logic [PC_W-1:0]    d_pc,
    output logic               q_valid,
    output logic [INSTR_W-1:0] q_instr,
    output logic [INSTR_W-1:0] q_imm,
    output logic [PC_W-1:0]    q_pc
);

    // Register update: clear beats load, load beats hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_instr <= '0;
            q_imm   <= '0;
            q_pc    <= '0;
        end else if (clr) begin
            q_valid <= 1'b0;
            q_instr <= '0;
            q_imm   <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_instr <= d_instr;
            q_imm   <= d_imm;
            q_pc    <= d_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, reset-vector boot, two-word assembly,
// stall/redirect handling, drives the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [INSTR_W-1:0] ifid_imm,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    pc
);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [PC_W-1:0]    pc_next;
    logic [INSTR_W-1:0] hold_instr;
    logic [INSTR_W-1:0] hold_instr_next;
    logic [PC_W-1:0]    hold_pc;
    logic [PC_W-1:0]    hold_pc_next;

    logic               ifid_en;
    logic               ifid_clr;
    logic               d_valid;
    logic [INSTR_W-1:0] d_instr;
    logic [INSTR_W-1:0] d_imm;
    logic [PC_W-1:0]    d_pc;

    logic [OPC_W-1:0]   opc;
    logic [PC_W-1:0]    boot_pc;
    logic [PC_W-1:0]    pc_plus1;

    assign opc       = imem_rdata[INSTR_W-1 -: OPC_W];
    assign boot_pc   = {{(PC_W-INSTR_W){1'b0}}, imem_rdata};
    assign pc_plus1  = pc + PC_W'(1);
    assign imem_addr = (state == BOOT) ? '0 : pc;

    // State, PC and half-instruction hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            hold_instr <= hold_instr_next;
            hold_pc    <= hold_pc_next;
        end
    end

    // Next state, next PC and IF/ID load; redirect beats stall
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_instr_next = hold_instr;
        hold_pc_next    = hold_pc;
        ifid_en         = 1'b0;
        ifid_clr        = 1'b0;
        d_valid         = 1'b0;
        d_instr         = '0;
        d_imm           = '0;
        d_pc            = pc;
        if (state == BOOT) begin
            pc_next    = boot_pc;
            state_next = FETCH_OP;
        end else if (redirect) begin
            pc_next    = redirect_pc;
            state_next = FETCH_OP;
            ifid_clr   = 1'b1;
        end else if (!stall) begin
            pc_next = pc_plus1;
            ifid_en = 1'b1;
            if (state == FETCH_IMM) begin
                state_next = FETCH_OP;
                d_valid    = 1'b1;
                d_instr    = hold_instr;
                d_imm      = imem_rdata;
                d_pc       = hold_pc;
            end else if (is_two_word(opc)) begin
                state_next      = FETCH_IMM;
                hold_instr_next = imem_rdata;
                hold_pc_next    = pc;
            end else begin
                d_valid = 1'b1;
                d_instr = imem_rdata;
            end
        end
    end

    ifid_reg #(
        .PC_W   (PC_W),
        .INSTR_W(INSTR_W)
    ) u_ifid (
        .clk    (clk),
        .rst    (rst),
        .en     (ifid_en),
        .clr    (ifid_clr),
        .d_valid(d_valid),
        .d_instr(d_instr),
        .d_imm  (d_imm),
        .d_pc   (d_pc),
        .q_valid(ifid_valid),
        .q_instr(ifid_instr),
        .q_imm  (ifid_imm),
        .q_pc   (ifid_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID
// entries, a monitor pops and compares each new valid entry.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_imm;
    logic [31:0] ifid_pc;
    logic [31:0] pc;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    int          checks;
    int          failures;
    logic [15:0] mem [0:255];
    logic [15:0] mem_top;
    logic        adv;

    fetch_stage #(.PC_W(32), .INSTR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_imm   (ifid_imm),
        .ifid_pc    (ifid_pc),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: low 256 words plus the top word
    always_comb begin
        if (imem_addr == 32'hFFFF_FFFF)
            imem_rdata = mem_top;
        else if (imem_addr < 32'd256)
            imem_rdata = mem[imem_addr[7:0]];
        else
            imem_rdata = 16'h0000;
    end

    // Note whether the last edge could load a new IF/ID entry
    always @(posedge clk) adv = redirect || !stall;

    // Monitor: compare each freshly loaded valid entry with the queue
    always @(negedge clk) begin
        if (!rst && adv && ifid_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL ifid_entry: unexpected instr=%h imm=%h pc=%h",
                         ifid_instr, ifid_imm, ifid_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (ifid_instr !== e.instr || ifid_imm !== e.imm ||
                    ifid_pc !== e.pc) begin
                    failures++;
                    $display("FAIL ifid_entry: got instr=%h imm=%h pc=%h expected instr=%h imm=%h pc=%h",
                             ifid_instr, ifid_imm, ifid_pc, e.instr, e.imm, e.pc);
                end
            end
        end
    end

    task automatic push(input logic [15:0] i, input logic [15:0] m,
                        input logic [31:0] p);
        exp_t e;
        e.instr = i;
        e.imm   = m;
        e.pc    = p;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_top     = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0020;
        mem[8'h20] = 16'h9800;
        mem[8'h21] = 16'hD000;
        mem[8'h22] = 16'h1234;
        mem[8'h23] = 16'h0800;
        mem[8'h24] = 16'h1000;
        mem[8'h25] = 16'h1800;
        mem[8'h26] = 16'h6000;
        mem[8'h27] = 16'h5555;
        mem[8'h40] = 16'h2000;
        mem[8'h41] = 16'h3800;
        mem[8'h42] = 16'hABCD;
        mem[8'h43] = 16'h4000;
        mem[8'h50] = 16'h4800;

        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'h0);
        chk("rst_instr", {16'd0, ifid_instr}, 32'h0);
        chk("rst_imm", {16'd0, ifid_imm}, 32'h0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("boot_addr", imem_addr, 32'h0);

        rst = 1'b0;
        tick();
        chk("boot_pc", pc, 32'h20);
        chk("boot_valid", {31'd0, ifid_valid}, 32'h0);

        push(16'h9800, 16'h0, 32'h20);
        tick();
        chk("add_pc", pc, 32'h21);
        chk("addr_follows_pc", imem_addr, 32'h21);

        tick();
        chk("ldm_bubble", {31'd0, ifid_valid}, 32'h0);
        chk("ldm_mid_pc", pc, 32'h22);
        push(16'hD000, 16'h1234, 32'h21);
        tick();
        chk("ldm_pc", pc, 32'h23);

        push(16'h0800, 16'h0, 32'h23);
        tick();
        chk("pre_stall_pc", pc, 32'h24);

        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        chk("stall_pc", pc, 32'h24);
        chk("stall_instr", {16'd0, ifid_instr}, 32'h0800);
        chk("stall_ifid_pc", ifid_pc, 32'h23);
        chk("stall_valid", {31'd0, ifid_valid}, 32'h1);

        push(16'h1000, 16'h0, 32'h24);
        tick();
        push(16'h1800, 16'h0, 32'h25);
        tick();
        chk("resume_pc", pc, 32'h26);

        tick();
        chk("std_bubble", {31'd0, ifid_valid}, 32'h0);
        chk("std_mid_pc", pc, 32'h27);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("redir_valid", {31'd0, ifid_valid}, 32'h0);
        chk("redir_instr", {16'd0, ifid_instr}, 32'h0);
        chk("redir_imm", {16'd0, ifid_imm}, 32'h0);
        chk("redir_pc", pc, 32'h40);

        push(16'h2000, 16'h0, 32'h40);
        tick();
        tick();
        push(16'h3800, 16'hABCD, 32'h41);
        tick();
        chk("ldd_pc", pc, 32'h43);

        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h50;
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("stall_redir_pc", pc, 32'h50);
        chk("stall_redir_valid", {31'd0, ifid_valid}, 32'h0);

        push(16'h4800, 16'h0, 32'h50);
        tick();
        chk("after_redir_pc", pc, 32'h51);

        mem_top     = 16'h5000;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        chk("top_pc", pc, 32'hFFFF_FFFF);
        push(16'h5000, 16'h0, 32'hFFFF_FFFF);
        tick();
        chk("wrap_pc", pc, 32'h0);
        push(16'h0020, 16'h0, 32'h0);
        tick();
        chk("wrap_next_pc", pc, 32'h1);

        mem_top     = 16'hD000;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap2_bubble", {31'd0, ifid_valid}, 32'h0);
        chk("wrap2_mid_pc", pc, 32'h0);
        push(16'hD000, 16'h0020, 32'hFFFF_FFFF);
        tick();
        chk("wrap2_pc", pc, 32'h1);

        redirect    = 1'b1;
        redirect_pc = 32'h26;
        tick();
        redirect = 1'b0;
        tick();
        chk("pre_rst_ifid_pc", ifid_pc, 32'h26);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, ifid_valid}, 32'h0);
        chk("mid_rst_instr", {16'd0, ifid_instr}, 32'h0);
        chk("mid_rst_imm", {16'd0, ifid_imm}, 32'h0);
        chk("mid_rst_ifid_pc", ifid_pc, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("reboot_pc", pc, 32'h20);
        push(16'h9800, 16'h0, 32'h20);
        tick();
        chk("reboot_run_pc", pc, 32'h21);

        @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
